hatch_ctrl: RTL and testbench
=============================

Name: hatch_ctrl

Overview:
- Incubation sequencer for the egg-hatch dot-matrix display.
- Advances the hatch stage number `num` (0..LAST_STAGE) at a fixed rate while incubation runs.
- Handles the start/pause keys, stalls stage timing on temperature faults and aborts on a sustained fault.
- Drives `st`, `num` and `temp` of the display block directly.

Parameters:
- CLK_HZ, 1000: clk cycles per second.
- STAGE_SEC, 5: good-temperature seconds per stage.
- LAST_STAGE, 11: final stage value. Reaching it means hatched.
- FAULT_SEC, 3: consecutive fault seconds that abort incubation.

Ports:
- clk  in  1  system clock, 1 kHz nominal.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse, debounced upstream.
- pause  in  1  one-cycle pulse, debounced upstream; toggles pause.
- temp_ok  in  1  1 = temperature in range.
- st  out  1  display enable.
- num  out  4  current stage.
- temp  out  1  1 = temperature fault (red overlay).
- done  out  1  hatch complete.
- fail  out  1  incubation aborted.

Behaviour:
- Reset (async, rst=1): state=IDLE; st=0, num=0, temp=0, done=0, fail=0; prescaler, sec_cnt and fault_cnt cleared. Asserting rst mid-operation returns to this state immediately. Release is synchronous to the next clk edge.
- States: IDLE, RUN, PAUSE, DONE, FAIL. All outputs are registered.
- IDLE: st=0, num=0.
  - start -> RUN on the next edge; prescaler, sec_cnt and fault_cnt cleared.
- RUN: st=1.
  - prescaler counts 0..CLK_HZ-1 and wraps. sec_tick=1 for exactly the cycle with prescaler==CLK_HZ-1.
  - On sec_tick with temp_ok=1: fault_cnt<=0.
    - If sec_cnt==STAGE_SEC-1: sec_cnt<=0 and num<=num+1. If num+1==LAST_STAGE, state<=DONE on the same edge.
    - Otherwise sec_cnt<=sec_cnt+1.
  - On sec_tick with temp_ok=0: sec_cnt and num hold; fault_cnt<=fault_cnt+1. If fault_cnt+1==FAULT_SEC, state<=FAIL.
  - temp <= ~temp_ok each cycle (1-cycle latency). temp_ok is sampled only on sec_tick for counting.
  - pause -> PAUSE. start is ignored.
- PAUSE: st=1; num, prescaler, sec_cnt and fault_cnt frozen; temp <= ~temp_ok.
  - pause -> RUN; counting resumes from the frozen values.
  - start is ignored.
- DONE: st=1, num=LAST_STAGE held, done=1, temp=0.
  - start -> RUN with num=0 and all counters cleared; done<=0.
- FAIL: st=1, num held, temp=1, fail=1.
  - start -> IDLE; fail<=0, temp<=0, num<=0.
- Simultaneous events:
  - sec_tick and pause in the same RUN cycle: the tick update is applied, then state<=PAUSE.
  - Stage advance and fault cannot coincide, because temp_ok selects exactly one branch.
  - start together with pause: start wins in IDLE/DONE/FAIL; pause wins in RUN/PAUSE.
- Widths:
  - prescaler: $clog2(CLK_HZ) bits.
  - sec_cnt: $clog2(STAGE_SEC) bits, minimum 1.
  - fault_cnt: $clog2(FAULT_SEC+1) bits.
  - num: 4 bits. LAST_STAGE must be ≤15 (elaboration check).

Decomposition:
- Shared package hatch_pkg:
  - state enum: IDLE=0, RUN=1, PAUSE=2, DONE=3, FAIL=4 (3 bits).
  - constants NUM_W=4 and LAST_STAGE_DEF=11, shared with the display block.
- Sub-module sec_tick_gen (params CLK_HZ; ports clk, rst, en, clr, tick).
  - Prescaler that freezes when en=0.
  - hatch_ctrl drives en=(state==RUN) and clr on entry to RUN from IDLE/DONE.

Test Plan (CLK_HZ=4, STAGE_SEC=2, LAST_STAGE=11, FAULT_SEC=3; one stage = 8 cycles):
1. rst pulse, then idle 20 cycles -> st=0, num=0, done=0, fail=0 throughout. rst asserted between edges -> outputs clear without waiting for an edge.
2. start, temp_ok=1 -> st=1 on the next edge; num steps 0→1 after 8 cycles, 1→2 after 16; num=11 and done=1 after 88 cycles; num stays 11 for a further 40 cycles.
3. RUN at num=3, pause mid-second, hold 30 cycles, then pause -> num stays 3 while paused; num=4 exactly after the remaining cycles of the interrupted stage (pause time excluded).
4. RUN at num=5, temp_ok=0 for 2 s, then 1 -> temp=1 one cycle after the drop; num frozen at 5 for 8 extra cycles; fault_cnt clears; no FAIL.
5. RUN, temp_ok=0 held for 3 seconds -> FAIL at the third tick: fail=1, temp=1, num held, st=1. Then start -> IDLE: st=0, num=0, fail=0.
6. DONE, then start -> RUN with num=0 and done=0. Reassert rst mid-RUN at num=7 -> all outputs reset immediately.

Source files
------------

// File: rtl/hatch_pkg.sv
// Shared types and constants for the egg-hatch incubation sequencer and display.
package hatch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  localparam int unsigned NUM_W          = 4;
  localparam int unsigned LAST_STAGE_DEF = 11;

endpackage

// File: rtl/hatch_ctrl_sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled, freezes otherwise.
module sec_tick_gen #(
  parameter int unsigned CLK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clr)
      pre_d = '0;
    else if (en)
      pre_d = (pre_q == PMAX) ? '0 : pre_q + 1'b1;
  end

  // Gated by en so a prescaler frozen at its top value cannot tick while paused.
  assign tick = en && (pre_q == PMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pre_q <= '0;
    else
      pre_q <= pre_d;
  end

endmodule

// File: rtl/hatch_ctrl.sv
// Incubation sequencer: advances the hatch stage once per STAGE_SEC good seconds,
// handles start/pause keys and aborts after FAULT_SEC consecutive fault seconds.
module hatch_ctrl
  import hatch_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 1000,
  parameter int unsigned STAGE_SEC  = 5,
  parameter int unsigned LAST_STAGE = LAST_STAGE_DEF,
  parameter int unsigned FAULT_SEC  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             temp_ok,
  output logic             st,
  output logic [NUM_W-1:0] num,
  output logic             temp,
  output logic             done,
  output logic             fail
);

  localparam int unsigned SEC_W = (STAGE_SEC > 1) ? $clog2(STAGE_SEC) : 1;
  localparam int unsigned FLT_W = (FAULT_SEC > 0) ? $clog2(FAULT_SEC + 1) : 1;
  localparam logic [NUM_W-1:0] LAST_V  = NUM_W'(LAST_STAGE);
  localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(STAGE_SEC - 1);
  localparam logic [FLT_W-1:0] FLT_TOP = FLT_W'(FAULT_SEC);

  if (LAST_STAGE > 15 || LAST_STAGE < 1) begin : g_bad_last_stage
    $error("hatch_ctrl: LAST_STAGE must be in 1..15");
  end

  state_t           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [FLT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic             st_q, st_d;
  logic             temp_q, temp_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             sec_tick;
  logic             pre_clr;

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q == RUN),
    .clr (pre_clr),
    .tick(sec_tick)
  );

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    sec_cnt_d   = sec_cnt_q;
    fault_cnt_d = fault_cnt_q;
    st_d        = st_q;
    temp_d      = temp_q;
    done_d      = done_q;
    fail_d      = fail_q;
    pre_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        st_d   = 1'b0;
        num_d  = '0;
        temp_d = 1'b0;
        done_d = 1'b0;
        fail_d = 1'b0;
        if (start) begin
          state_d     = RUN;
          st_d        = 1'b1;
          sec_cnt_d   = '0;
          fault_cnt_d = '0;
          pre_clr     = 1'b1;
        end
      end

      RUN: begin
        st_d   = 1'b1;
        temp_d = ~temp_ok;
        if (sec_tick) begin
          if (temp_ok) begin
            fault_cnt_d = '0;
            if (sec_cnt_q == SEC_TOP) begin
              sec_cnt_d = '0;
              num_d     = num_q + 1'b1;
              if (num_q + 1'b1 == LAST_V) begin
                state_d = DONE;
                done_d  = 1'b1;
                temp_d  = 1'b0;
              end
            end else begin
              sec_cnt_d = sec_cnt_q + 1'b1;
            end
          end else begin
            fault_cnt_d = fault_cnt_q + 1'b1;
            if (fault_cnt_q + 1'b1 == FLT_TOP) begin
              state_d = FAIL;
              fail_d  = 1'b1;
              temp_d  = 1'b1;
            end
          end
        end
        // Tick update lands first; pause only redirects if we are still running.
        if (pause && state_d == RUN)
          state_d = PAUSE;
      end

      PAUSE: begin
        st_d   = 1'b1;
        temp_d = ~temp_ok;
        if (pause)
          state_d = RUN;
      end

      DONE: begin
        st_d   = 1'b1;
        num_d  = LAST_V;
        temp_d = 1'b0;
        done_d = 1'b1;
        if (start) begin
          state_d     = RUN;
          num_d       = '0;
          sec_cnt_d   = '0;
          fault_cnt_d = '0;
          done_d      = 1'b0;
          pre_clr     = 1'b1;
        end
      end

      FAIL: begin
        st_d   = 1'b1;
        temp_d = 1'b1;
        fail_d = 1'b1;
        if (start) begin
          state_d = IDLE;
          st_d    = 1'b0;
          num_d   = '0;
          temp_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        st_d    = 1'b0;
        num_d   = '0;
        temp_d  = 1'b0;
        done_d  = 1'b0;
        fail_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      sec_cnt_q   <= '0;
      fault_cnt_q <= '0;
      st_q        <= 1'b0;
      temp_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      sec_cnt_q   <= sec_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      st_q        <= st_d;
      temp_q      <= temp_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  assign st   = st_q;
  assign num  = num_q;
  assign temp = temp_q;
  assign done = done_q;
  assign fail = fail_q;

endmodule

// File: tb/tb_hatch_ctrl.sv
// Directed bench for hatch_ctrl with CLK_HZ=4, STAGE_SEC=2 (one stage = 8 run cycles).
module tb_hatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic       temp_ok;
  logic       st;
  logic [3:0] num;
  logic       temp;
  logic       done;
  logic       fail;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hatch_ctrl #(
    .CLK_HZ    (4),
    .STAGE_SEC (2),
    .LAST_STAGE(11),
    .FAULT_SEC (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pause  (pause),
    .temp_ok(temp_ok),
    .st     (st),
    .num    (num),
    .temp   (temp),
    .done   (done),
    .fail   (fail)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; temp_ok = 1'b1;
    #1;
    total++;
    if ({st, num, temp, done, fail} !== 8'h00)
      $display("FAIL reset_state: got st=%b num=%0d temp=%b done=%b fail=%b, want all 0", st, num, temp, done, fail);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({st, num, done, fail} !== 7'h00)
        $display("FAIL idle_hold[%0d]: got st=%b num=%0d done=%b fail=%b, want 0", i, st, num, done, fail);
      else passed++;
    end
    pulse_start();
    total++;
    if (st !== 1'b1) $display("FAIL idle_start_st: got %b want 1", st);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({st, num, temp, done, fail} !== 8'h00)
      $display("FAIL async_reset_idle: got st=%b num=%0d temp=%b, want all 0", st, num, temp);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stage_advance();
    do_reset();
    pulse_start();
    total++;
    if (st !== 1'b1 || num !== 4'd0) $display("FAIL run_entry: got st=%b num=%0d want st=1 num=0", st, num);
    else passed++;
    cyc(7);
    total++;
    if (num !== 4'd0) $display("FAIL stage0_hold_7: got num=%0d want 0", num);
    else passed++;
    cyc(1);
    total++;
    if (num !== 4'd1) $display("FAIL stage1_at_8: got num=%0d want 1", num);
    else passed++;
    cyc(7);
    total++;
    if (num !== 4'd1) $display("FAIL stage1_hold_15: got num=%0d want 1", num);
    else passed++;
    cyc(1);
    total++;
    if (num !== 4'd2) $display("FAIL stage2_at_16: got num=%0d want 2", num);
    else passed++;
    cyc(71);
    total++;
    if (num !== 4'd10 || done !== 1'b0) $display("FAIL pre_done_87: got num=%0d done=%b want num=10 done=0", num, done);
    else passed++;
    cyc(1);
    total++;
    if (num !== 4'd11 || done !== 1'b1 || st !== 1'b1 || temp !== 1'b0)
      $display("FAIL done_at_88: got num=%0d done=%b st=%b temp=%b want 11/1/1/0", num, done, st, temp);
    else passed++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (num !== 4'd11 || done !== 1'b1)
        $display("FAIL done_hold[%0d]: got num=%0d done=%b want 11/1", i, num, done);
      else passed++;
    end
  endtask

  task automatic test_pause();
    do_reset();
    pulse_start();
    cyc(24);
    total++;
    if (num !== 4'd3) $display("FAIL pause_pre_num: got %0d want 3", num);
    else passed++;
    cyc(2);
    pause = 1'b1;
    start = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if (num !== 4'd3 || st !== 1'b1)
        $display("FAIL paused_hold[%0d]: got num=%0d st=%b want 3/1", i, num, st);
      else passed++;
    end
    pulse_pause();
    cyc(4);
    total++;
    if (num !== 4'd3) $display("FAIL resume_hold: got num=%0d want 3", num);
    else passed++;
    cyc(1);
    total++;
    if (num !== 4'd4) $display("FAIL resume_advance: got num=%0d want 4", num);
    else passed++;
  endtask

  task automatic test_temp_fault_recover();
    do_reset();
    pulse_start();
    cyc(40);
    total++;
    if (num !== 4'd5 || temp !== 1'b0) $display("FAIL fault_pre: got num=%0d temp=%b want 5/0", num, temp);
    else passed++;
    temp_ok = 1'b0;
    cyc(1);
    total++;
    if (temp !== 1'b1) $display("FAIL temp_latency: got temp=%b want 1", temp);
    else passed++;
    cyc(7);
    total++;
    if (num !== 4'd5 || fail !== 1'b0) $display("FAIL fault_2s: got num=%0d fail=%b want 5/0", num, fail);
    else passed++;
    temp_ok = 1'b1;
    cyc(1);
    total++;
    if (temp !== 1'b0) $display("FAIL temp_clear: got temp=%b want 0", temp);
    else passed++;
    cyc(6);
    total++;
    if (num !== 4'd5) $display("FAIL fault_stall_55: got num=%0d want 5", num);
    else passed++;
    cyc(1);
    total++;
    if (num !== 4'd6 || fail !== 1'b0) $display("FAIL fault_stall_56: got num=%0d fail=%b want 6/0", num, fail);
    else passed++;
    temp_ok = 1'b0;
    cyc(4);
    temp_ok = 1'b1;
    total++;
    if (fail !== 1'b0 || st !== 1'b1) $display("FAIL fault_cnt_cleared: got fail=%b st=%b want 0/1", fail, st);
    else passed++;
  endtask

  task automatic test_fail_abort();
    do_reset();
    pulse_start();
    cyc(16);
    total++;
    if (num !== 4'd2) $display("FAIL abort_pre: got num=%0d want 2", num);
    else passed++;
    temp_ok = 1'b0;
    cyc(11);
    total++;
    if (fail !== 1'b0 || num !== 4'd2) $display("FAIL abort_early: got fail=%b num=%0d want 0/2", fail, num);
    else passed++;
    cyc(1);
    total++;
    if (fail !== 1'b1 || temp !== 1'b1 || num !== 4'd2 || st !== 1'b1 || done !== 1'b0)
      $display("FAIL abort_third_tick: got fail=%b temp=%b num=%0d st=%b done=%b want 1/1/2/1/0", fail, temp, num, st, done);
    else passed++;
    temp_ok = 1'b1;
    cyc(5);
    total++;
    if (fail !== 1'b1 || num !== 4'd2 || temp !== 1'b1) $display("FAIL abort_hold: got fail=%b num=%0d temp=%b want 1/2/1", fail, num, temp);
    else passed++;
    pulse_start();
    total++;
    if ({st, num, temp, done, fail} !== 8'h00)
      $display("FAIL fail_to_idle: got st=%b num=%0d temp=%b fail=%b want all 0", st, num, temp, fail);
    else passed++;
  endtask

  task automatic test_done_restart();
    do_reset();
    pulse_start();
    cyc(88);
    total++;
    if (done !== 1'b1) $display("FAIL restart_pre_done: got done=%b want 1", done);
    else passed++;
    pulse_start();
    total++;
    if (num !== 4'd0 || done !== 1'b0 || st !== 1'b1) $display("FAIL done_restart: got num=%0d done=%b st=%b want 0/0/1", num, done, st);
    else passed++;
    cyc(56);
    total++;
    if (num !== 4'd7) $display("FAIL restart_num7: got num=%0d want 7", num);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({st, num, temp, done, fail} !== 8'h00)
      $display("FAIL async_reset_run: got st=%b num=%0d temp=%b done=%b fail=%b want all 0", st, num, temp, done, fail);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    total++;
    if (st !== 1'b0 || num !== 4'd0) $display("FAIL post_reset_idle: got st=%b num=%0d want 0/0", st, num);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stage_advance();
    test_pause();
    test_temp_fault_recover();
    test_fail_abort();
    test_done_restart();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
